ysyx_23060191_ifu: RTL and testbench

Instruction fetch unit for the multicycle RV32E/I core. It owns the architectural PC and issues one read per instruction to instruction memory over an AXI4-Lite-style AR/R channel pair. It presents the fetched 32-bit instruction to the IDU through a valid/ready handshake, then waits for the PCU to supply the next PC (pc+4, jal or jalr target) before fetching again. It is the producer side of the instruction interface that the IDU decodes.

---
 rtl/ysyx_23060191_ifu_pkg.sv | 14 +
 rtl/ysyx_23060191_ifu_cnt.sv | 16 +
 rtl/ysyx_23060191_ifu.sv | 70 +++++++
 tb/tb_ysyx_23060191_ifu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060191_ifu_pkg.sv
// ysyx_23060191_ifu_pkg: shared constants and state encoding for the instruction fetch unit
package ysyx_23060191_ifu_pkg;
  localparam int IFU_CPU_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RESP    = 3'd2,
    S_HOLD    = 3'd3,
    S_WAIT_PC = 3'd4,
    S_ERR     = 3'd5
  } ifu_state_t;
endpackage

// File: rtl/ysyx_23060191_ifu_cnt.sv
// ysyx_23060191_ifu_cnt: free-running wrap counter with enable, reusable for perf counters
module ysyx_23060191_ifu_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/ysyx_23060191_ifu.sv
// ysyx_23060191_ifu: owns the PC, fetches one instruction per AR/R transaction, hands it to the IDU
module ysyx_23060191_ifu
  import ysyx_23060191_ifu_pkg::*;
#(
  parameter int                   CPU_WIDTH = IFU_CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [CPU_WIDTH-1:0] pc,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic                 pc_next_valid,
  input  logic [CPU_WIDTH-1:0] pc_next,
  output logic [CPU_WIDTH-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic                 fetch_err,
  output logic [31:0]          fetch_cnt
);
  ifu_state_t r_state, w_next;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [31:0] r_inst;
  logic w_deliver;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_REQ;
      S_REQ:     w_next = arready ? S_RESP : S_REQ;
      S_RESP:    w_next = !rvalid ? S_RESP : (rresp == RESP_OKAY) ? S_HOLD : S_ERR;
      S_HOLD:    w_next = inst_ready ? S_WAIT_PC : S_HOLD;
      S_WAIT_PC: w_next = !pc_next_valid ? S_WAIT_PC : (pc_next[1:0] != 2'b00) ? S_ERR : S_REQ;
      default:   w_next = S_ERR;
    endcase
  end
  always_comb begin
    arvalid    = (r_state == S_REQ);
    rready     = (r_state == S_RESP);
    inst_valid = (r_state == S_HOLD);
    fetch_err  = (r_state == S_ERR);
    w_deliver  = inst_valid && inst_ready;
  end
  // a misaligned target is still latched so the faulting PC is visible while halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else if (r_state == S_WAIT_PC && pc_next_valid) r_pc <= pc_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inst <= '0;
    else if (rready && rvalid && rresp == RESP_OKAY) r_inst <= rdata;
  end
  ysyx_23060191_ifu_cnt #(.W(32)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_deliver),
    .o_cnt (fetch_cnt)
  );
  assign pc     = r_pc;
  assign araddr = r_pc;
  assign inst   = r_inst;
endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// tb_ysyx_23060191_ifu: scoreboard bench; stimulus pushes expected AR addresses and deliveries, a monitor checks them
module tb_ysyx_23060191_ifu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc, inst, araddr, rdata, pc_next, fetch_cnt;
  logic inst_valid, inst_ready, pc_next_valid, arvalid, arready, rvalid, rready, fetch_err;
  logic [1:0] rresp;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;
  logic [31:0] ar_q[$];
  exp_t inst_q[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] cnt_model = 0;

  ysyx_23060191_ifu dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_next_valid(pc_next_valid), .pc_next(pc_next),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && arvalid && arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", araddr, 32'hxxxx_xxxx);
      else chk("ar_addr", araddr, ar_q.pop_front());
    end
    if (rst_n && inst_valid && inst_ready) begin
      if (inst_q.size() == 0) chk("deliver_unexpected", inst, 32'hxxxx_xxxx);
      else begin
        exp_t e;
        e = inst_q.pop_front();
        chk("deliver_pc", pc, e.pc);
        chk("deliver_inst", inst, e.inst);
        chk("deliver_cnt", fetch_cnt, e.cnt);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    {inst_ready, pc_next_valid, arready, rvalid} = '0;
    pc_next = '0; rdata = '0; rresp = '0;
    cnt_model = 0;
    step();
    chk("rst_pc", araddr, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_flags", {inst_valid, arvalid, rready, fetch_err}, 4'b0000);
    chk("rst_cnt", fetch_cnt, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_arvalid", arvalid, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                       input int arw, input int rw, input int irw, input bit pulse,
                       input logic [31:0] nxt);
    int n = 0;
    ar_q.push_back(a);
    while (!arvalid && n < 20) begin step(); n++; end
    chk("ar_timeout", arvalid, 1'b1);
    repeat (arw) begin
      chk("ar_stable", {arvalid, rready, araddr}, {2'b10, a});
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    repeat (rw) begin
      chk("r_wait", {rready, arvalid, inst_valid}, 3'b100);
      step();
    end
    rdata = d; rresp = resp; rvalid = 1'b1;
    if (resp == 2'b00) inst_q.push_back('{pc: a, inst: d, cnt: cnt_model});
    step();
    rvalid = 1'b0; rdata = 32'hdead_beef;
    if (resp != 2'b00) begin
      chk("rerr_flags", {fetch_err, inst_valid, arvalid}, 3'b100);
      chk("rerr_cnt", fetch_cnt, cnt_model);
      return;
    end
    repeat (irw) begin
      pc_next = 32'h8000_0201;
      pc_next_valid = pulse;
      chk("hold_stable", {inst_valid, inst, pc}, {1'b1, d, a});
      step();
    end
    pc_next_valid = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    cnt_model++;
    chk("wait_cnt", fetch_cnt, cnt_model);
    pc_next = nxt; pc_next_valid = 1'b1;
    step();
    pc_next_valid = 1'b0;
    chk("next_pc", pc, nxt);
    chk("next_err", fetch_err, nxt[1:0] != 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    do_reset();
    step();
    chk("first_arvalid", arvalid, 1'b1);
    fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 0, 32'h8000_0004);
    fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 3, 2, 4, 0, 32'h8000_0008);
    chk("bp_cnt", fetch_cnt, 32'd2);
    fetch(32'h8000_0008, 32'h1000_006f, 2'b00, 0, 0, 2, 1, 32'h8000_0100);
    fetch(32'h8000_0100, 32'h0000_8067, 2'b00, 0, 0, 0, 0, 32'h8000_0102);
    bad = 0;
    repeat (20) begin
      if (arvalid || !fetch_err) bad++;
      step();
    end
    chk("err_absorb", bad, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {fetch_err, araddr}, {1'b0, 32'h8000_0000});
    do_reset();
    fetch(32'h8000_0000, 32'h0000_0013, 2'b00, 0, 0, 0, 0, 32'h8000_0004);
    fetch(32'h8000_0004, 32'h1234_5678, 2'b10, 0, 1, 0, 0, 32'h0);
    chk("rerr_inst_kept", inst, 32'h0000_0013);
    chk("rerr_cnt_kept", fetch_cnt, 32'd1);
    bad = 0;
    repeat (10) begin
      if (arvalid || rready || inst_valid) bad++;
      step();
    end
    chk("rerr_quiet", bad, 0);
    do_reset();
    ar_q.push_back(32'h8000_0000);
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("pre_rst_rready", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {rready, arvalid, pc}, {2'b00, 32'h8000_0000});
    rdata = 32'hdead_beef; rvalid = 1'b1;
    step();
    step();
    chk("late_r_dropped", {rready, inst_valid, inst}, {2'b00, 32'h0});
    rvalid = 1'b0;
    rst_n = 1'b1;
    fetch(32'h8000_0000, 32'h0000_0297, 2'b00, 0, 0, 0, 0, 32'h8000_0004);
    chk("restart_cnt", fetch_cnt, 32'd1);
    step();
    chk("ar_q_empty", ar_q.size(), 0);
    chk("inst_q_empty", inst_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
